// File: rtl/instr_mem_sync.sv
// rtl/instr_mem_sync.sv - instruction memory with zeroing sweep, read-first fetch port and stall hold
module instr_mem_sync #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  output logic [DATA_W-1:0] rd,
  output logic              rd_valid,
  output logic              addr_err
);

  // Storage index width; the extra address bits only matter for range checks.
  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_V  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    READY = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [IDX_W-1:0]  clr_cnt;
  logic              clr_last;
  logic              prog_ok;
  logic              fetch_ok;
  logic [IDX_W-1:0]  prog_idx;
  logic [IDX_W-1:0]  fetch_idx;
  logic              hold;
  logic              fetch_go;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign clr_last  = (clr_cnt == LAST_IDX);
  assign prog_ok   = ({1'b0, prog_addr} < DEPTH_V);
  assign fetch_ok  = ({1'b0, fetch_addr} < DEPTH_V);
  assign prog_idx  = prog_addr[IDX_W-1:0];
  assign fetch_idx = fetch_addr[IDX_W-1:0];
  assign ready     = (state != CLEAR);

  // State register; reset always restarts the clear sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
    end else begin
      state <= state_nx;
    end
  end

  // Next state plus the single memory write port shared by the sweep and programming.
  always_comb begin
    state_nx  = state;
    hold      = 1'b0;
    fetch_go  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        if (clr_last) begin
          state_nx = READY;
        end
      end
      READY, HOLD: begin
        // A stall only freezes a result that is actually valid.
        hold     = stall && rd_valid;
        fetch_go = fetch_req && !hold;
        state_nx = hold ? HOLD : READY;
        if (prog_we && prog_ok) begin
          mem_we    = 1'b1;
          mem_waddr = prog_idx;
          mem_wdata = prog_data;
        end
      end
      default: begin
        state_nx = CLEAR;
      end
    endcase
  end

  // Memory array write; no reset, the sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Sweep counter and fetch result registers; reads see pre-write contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt  <= '0;
      rd       <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else if (state == CLEAR) begin
      clr_cnt  <= clr_last ? '0 : clr_cnt + IDX_W'(1);
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      if (!hold) begin
        rd_valid <= fetch_req;
        if (fetch_req) begin
          rd <= fetch_ok ? mem[fetch_idx] : '0;
        end
      end
      addr_err <= (fetch_go && !fetch_ok) || (prog_we && !prog_ok);
    end
  end

endmodule

// File: tb/tb_instr_mem_sync.sv
// tb/tb_instr_mem_sync.sv - directed vector bench for instr_mem_sync
module tb_instr_mem_sync;

  logic        clk;
  logic        rst;
  logic        ready;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [31:0] prog_data;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        stall;
  logic [31:0] rd;
  logic        rd_valid;
  logic        addr_err;

  int total;
  int bad;

  typedef struct {
    logic        pwe;
    logic [7:0]  pa;
    logic [31:0] pd;
    logic        fr;
    logic [7:0]  fa;
    logic        st;
    logic [31:0] erd;
    logic        ev;
    logic        ee;
  } vec_t;

  vec_t vq[$];

  instr_mem_sync #(.DATA_W(32), .ADDR_W(8), .DEPTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .ready(ready),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .fetch_req(fetch_req),
    .fetch_addr(fetch_addr),
    .stall(stall),
    .rd(rd),
    .rd_valid(rd_valid),
    .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic pwe, input logic [7:0] pa, input logic [31:0] pd,
                              input logic fr, input logic [7:0] fa, input logic st,
                              input logic [31:0] erd, input logic ev, input logic ee);
    vec_t v;
    v.pwe = pwe; v.pa = pa; v.pd = pd; v.fr = fr; v.fa = fa; v.st = st;
    v.erd = erd; v.ev = ev; v.ee = ee;
    return v;
  endfunction

  task automatic drive(input logic pwe, input logic [7:0] pa, input logic [31:0] pd,
                       input logic fr, input logic [7:0] fa, input logic st);
    @(negedge clk);
    prog_we = pwe; prog_addr = pa; prog_data = pd;
    fetch_req = fr; fetch_addr = fa; stall = st;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_chk(input logic [7:0] a, input logic [31:0] exp, input string name);
    drive(1'b0, 8'd0, 32'd0, 1'b1, a, 1'b0);
    chk(name, rd, exp);
    chk({name, "_valid"}, {31'd0, rd_valid}, 32'd1);
  endtask

  task automatic sweep_chk(input string name);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      chk(name, {31'd0, ready}, (i == 8) ? 32'd1 : 32'd0);
      chk({name, "_valid"}, {31'd0, rd_valid}, 32'd0);
      chk({name, "_err"}, {31'd0, addr_err}, 32'd0);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    fetch_req = 1'b0; fetch_addr = '0; stall = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rd", rd, 32'd0);
    chk("rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_err", {31'd0, addr_err}, 32'd0);

    // Sweep with fetch/program traffic that must be ignored.
    @(negedge clk);
    rst = 1'b0;
    prog_we = 1'b1; prog_addr = 8'd3; prog_data = 32'hFFFF_FFFF;
    fetch_req = 1'b1; fetch_addr = 8'd9;
    sweep_chk("sweep_ready");
    prog_we = 1'b0; fetch_req = 1'b0;

    for (int a = 0; a < 8; a++) fetch_chk(a[7:0], 32'd0, "clear_word");

    //             pwe   pa     pd            fr    fa     st    erd           ev    ee
    vq.push_back(mk(1'b1, 8'd0, 32'h20010003, 1'b0, 8'd0, 1'b0, 32'h00000000, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 8'd1, 32'h20020009, 1'b0, 8'd0, 1'b0, 32'h00000000, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 8'd2, 32'h00221020, 1'b0, 8'd0, 1'b0, 32'h00000000, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 8'd0, 32'h0,        1'b1, 8'd0, 1'b0, 32'h20010003, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 8'd0, 32'h0,        1'b1, 8'd1, 1'b0, 32'h20020009, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 8'd0, 32'h0,        1'b1, 8'd2, 1'b0, 32'h00221020, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 8'd0, 32'h0,        1'b0, 8'd0, 1'b0, 32'h00221020, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 8'd0, 32'h0,        1'b0, 8'd0, 1'b1, 32'h00221020, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 8'd0, 32'h0,        1'b1, 8'd1, 1'b0, 32'h20020009, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 8'd0, 32'h0,        1'b1, 8'd2, 1'b1, 32'h20020009, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 8'd1, 32'hDEADBEEF, 1'b1, 8'd2, 1'b1, 32'h20020009, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 8'd0, 32'h0,        1'b1, 8'd2, 1'b1, 32'h20020009, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 8'd0, 32'h0,        1'b1, 8'd2, 1'b0, 32'h00221020, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 8'd0, 32'h0,        1'b1, 8'd1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 8'd0, 32'hFFFFFFFF, 1'b1, 8'd0, 1'b0, 32'h20010003, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 8'd0, 32'h0,        1'b1, 8'd0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 8'd0, 32'h0,        1'b1, 8'd9, 1'b0, 32'h00000000, 1'b1, 1'b1));
    vq.push_back(mk(1'b0, 8'd0, 32'h0,        1'b0, 8'd0, 1'b0, 32'h00000000, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 8'd12, 32'h12345678, 1'b0, 8'd0, 1'b0, 32'h00000000, 1'b0, 1'b1));
    vq.push_back(mk(1'b0, 8'd0, 32'h0,        1'b1, 8'd4, 1'b0, 32'h00000000, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 8'd0, 32'h0,        1'b1, 8'd8, 1'b0, 32'h00000000, 1'b1, 1'b1));
    vq.push_back(mk(1'b0, 8'd0, 32'h0,        1'b1, 8'd7, 1'b0, 32'h00000000, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 8'd8, 32'hAAAAAAAA, 1'b0, 8'd0, 1'b0, 32'h00000000, 1'b0, 1'b1));
    vq.push_back(mk(1'b0, 8'd0, 32'h0,        1'b1, 8'd0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 8'd200, 32'h5555AAAA, 1'b1, 8'd3, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1));
    vq.push_back(mk(1'b0, 8'd0, 32'h0,        1'b0, 8'd0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].pwe, vq[i].pa, vq[i].pd, vq[i].fr, vq[i].fa, vq[i].st);
      chk($sformatf("vec%0d_rd", i), rd, vq[i].erd);
      chk($sformatf("vec%0d_valid", i), {31'd0, rd_valid}, {31'd0, vq[i].ev});
      chk($sformatf("vec%0d_err", i), {31'd0, addr_err}, {31'd0, vq[i].ee});
      chk($sformatf("vec%0d_ready", i), {31'd0, ready}, 32'd1);
    end

    // Fill every word, then reset from READY and again mid-sweep.
    for (int a = 0; a < 8; a++) drive(1'b1, a[7:0], {24'hA5A5A5, a[7:0]}, 1'b0, 8'd0, 1'b0);
    fetch_chk(8'd7, 32'hA5A5A507, "prefill_word");
    @(negedge clk);
    rst = 1'b1;
    prog_we = 1'b0; fetch_req = 1'b0;
    @(posedge clk);
    #1;
    chk("rst2_rd", rd, 32'd0);
    chk("rst2_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst2_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("partial_sweep_ready", {31'd0, ready}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sweep_chk("resweep_ready");
    for (int a = 0; a < 8; a++) fetch_chk(a[7:0], 32'd0, "resweep_word");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_sync.md
INSTR_MEM_SYNC -- requirements
Module: instr_mem_sync

Interface
REQ-001 Parameter DATA_W, default 32: instruction word width in bits.
REQ-002 Parameter ADDR_W, default 8: word-address width in bits.
REQ-003 Parameter DEPTH, default 256: number of stored words; legal range 1..2**ADDR_W.
REQ-004 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port ready, output, 1: high when the block accepts fetch and program operations.
REQ-007 Port prog_we, input, 1: program-write strobe.
REQ-008 Port prog_addr, input, ADDR_W: program-write word address.
REQ-009 Port prog_data, input, DATA_W: program-write data.
REQ-010 Port fetch_req, input, 1: fetch request.
REQ-011 Port fetch_addr, input, ADDR_W: fetch word address.
REQ-012 Port stall, input, 1: consumer stall; holds the current fetch result.
REQ-013 Port rd, output, DATA_W: fetched instruction word.
REQ-014 Port rd_valid, output, 1: rd holds a valid fetch result.
REQ-015 Port addr_err, output, 1: one-cycle pulse flagging an out-of-range fetch or program address.

Function
REQ-016 The block SHALL use a three-state FSM: CLEAR, READY, HOLD.
REQ-017 CLEAR: a counter SHALL walk addresses 0..DEPTH-1, writing all-zero (NOP) one word per cycle; ready=0 throughout.
REQ-018 CLEAR -> READY SHALL occur on the cycle after address DEPTH-1 is written, so ready rises exactly DEPTH cycles after rst deasserts.
REQ-019 READY: when prog_we=1 and prog_addr<DEPTH, mem[prog_addr] SHALL take prog_data at the clock edge.
REQ-020 READY: when fetch_req=1 and fetch_addr<DEPTH, rd SHALL equal mem[fetch_addr] and rd_valid SHALL be 1 one cycle later (latency 1).
REQ-021 A fetch and a program write to the same address in the same cycle SHALL return the old (pre-write) data (read-first).
REQ-022 READY with fetch_req=0 and stall=0: rd_valid SHALL be 0 next cycle; rd SHALL keep its last value.
REQ-023 READY -> HOLD SHALL occur when stall=1 and rd_valid=1; in HOLD, rd and rd_valid SHALL stay constant and new fetch_req SHALL be ignored.
REQ-024 HOLD -> READY SHALL occur on the first cycle with stall=0; a fetch_req present in that cycle SHALL be serviced with normal latency.
REQ-025 Program writes SHALL be accepted in HOLD; a write to the held address SHALL NOT alter rd.
REQ-026 An out-of-range address (>=DEPTH) SHALL cause no memory write; for a fetch, rd SHALL be 0 and rd_valid 1. Either case SHALL pulse addr_err for one cycle, aligned with the rd update for fetches and one cycle after the write for program writes.
REQ-027 In CLEAR, fetch_req and prog_we SHALL be ignored; rd_valid and addr_err SHALL stay 0.
REQ-028 stall while rd_valid=0 SHALL have no effect.

Reset
REQ-029 rst=1 at a clock edge SHALL force state CLEAR, clear counter=0, rd=0, rd_valid=0, addr_err=0, ready=0.
REQ-030 Reset in any state, including mid-CLEAR, SHALL restart the clear sweep from address 0.
REQ-031 Memory contents SHALL be all-zero after the sweep, regardless of prior content.

Verification
REQ-032 Reset sweep: DEPTH=8, pulse rst -> ready=0 for 8 cycles then 1; fetch of every address returns 0x00000000.
REQ-033 Program/fetch: write 0x20010003 @0, 0x20020009 @1, 0x00221020 @2 -> fetching 0,1,2 back-to-back gives those words one cycle after each request, with rd_valid=1 for three consecutive cycles.
REQ-034 Stall: fetch @1, stall=1 for 3 cycles with fetch_req @2 held -> rd=0x20020009 held for 3 cycles; after stall drops, rd=0x00221020 on the next cycle.
REQ-035 Collision: fetch @0 and write 0xFFFFFFFF @0 in the same cycle -> rd=0x20010003; a following fetch @0 -> 0xFFFFFFFF.
REQ-036 Range: DEPTH=8, fetch @9 -> rd=0, rd_valid=1, addr_err pulses 1 cycle; program @12 -> memory unchanged, addr_err pulses.
REQ-037 Mid-sweep reset: assert rst at sweep cycle 4 after addresses 0..7 were programmed -> sweep restarts; ready rises 8 cycles after rst drops; all words read 0.
